// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter
//
// Purpose:
//   Shares a single saturating adder between two requesters using a
//   round-robin arbiter. The granted operand pair is summed at full
//   precision (WIDTH+1 bits), clamped to the shared limit _m_max, and
//   registered into a one-entry output buffer. The buffered result is
//   tagged with the id of the requester that produced it. A drain and a
//   new accept may happen on the same edge, so the block sustains one
//   operation per cycle.
//
// Ports:
//   _m_clk        clock, rising edge
//   _m_rst        asynchronous active-high reset
//   _m_req0_valid requester 0 has an operand pair
//   _m_req0_a/b   requester 0 operands (WIDTH bits each)
//   _m_req1_valid requester 1 has an operand pair
//   _m_req1_a/b   requester 1 operands (WIDTH bits each)
//   _m_max        saturation limit, sampled on the accepting edge
//   _m_out_ready  consumer takes the buffered result this cycle
//   __output      packed {req0_ready, req1_ready, out_valid, out_id,
//                 out_sat, out_data[WIDTH-1:0]}, MSB first

module sat_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             _m_clk,
  input  logic             _m_rst,
  input  logic             _m_req0_valid,
  input  logic [WIDTH-1:0] _m_req0_a,
  input  logic [WIDTH-1:0] _m_req0_b,
  input  logic             _m_req1_valid,
  input  logic [WIDTH-1:0] _m_req1_a,
  input  logic [WIDTH-1:0] _m_req1_b,
  input  logic [WIDTH-1:0] _m_max,
  input  logic             _m_out_ready,
  output logic [WIDTH+4:0] __output
);

  logic             out_valid;
  logic             out_id;
  logic             out_sat;
  logic [WIDTH-1:0] out_data;
  logic             last;

  logic             free;
  logic             grant;
  logic             req0_ready;
  logic             req1_ready;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   sum;
  logic             sum_sat;

  // The buffer can take a new result when it is empty or is being drained
  // on this same edge.
  assign free = !out_valid || _m_out_ready;

  // Round-robin grant: a lone requester always wins; under contention the
  // requester that was not served most recently wins. With no valid
  // request the grant value is irrelevant because both readys are gated
  // by their valids.
  always_comb begin
    grant = 1'b0;
    if (_m_req0_valid && _m_req1_valid) begin
      grant = !last;
    end else if (_m_req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = free && _m_req0_valid && !grant;
  assign req1_ready = free && _m_req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  // Operands of the granted requester feed the single shared adder.
  assign sel_a = grant ? _m_req1_a : _m_req0_a;
  assign sel_b = grant ? _m_req1_b : _m_req0_b;

  // The extra bit keeps the carry-out so a wrapped sum is still seen as
  // exceeding the limit.
  assign sum     = {1'b0, sel_a} + {1'b0, sel_b};
  assign sum_sat = sum > {1'b0, _m_max};

  // Output buffer and round-robin pointer. An accept always wins over a
  // drain, which gives back-to-back replacement. `last` only moves on an
  // accept, so stalls and idle cycles leave the arbitration order intact.
  // Reset sets `last` to 1 so requester 0 wins the first contested cycle.
  always_ff @(posedge _m_clk or posedge _m_rst) begin
    if (_m_rst) begin
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_sat   <= 1'b0;
      out_data  <= '0;
      last      <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_id    <= grant;
      out_sat   <= sum_sat;
      out_data  <= sum_sat ? _m_max : sum[WIDTH-1:0];
      last      <= grant;
    end else if (out_valid && _m_out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign __output = {req0_ready, req1_ready, out_valid, out_id, out_sat, out_data};

endmodule

// File: doc/sat_add_arbiter.md
# sat_add_arbiter

Round-robin arbiter that shares one saturating adder between two requesters. Each requester presents an operand pair over a valid/ready handshake. The granted pair is summed, clamped to a shared limit and registered into a one-entry output buffer, tagged with the requester id. The block sits in front of the saturating adder datapath so two producers can use a single adder without duplicating it.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits.

Ports:
- _m_clk  in  1  clock; all state updates on the rising edge.
- _m_rst  in  1  reset, asynchronous, active-high.
- _m_req0_valid  in  1  requester 0 has an operand pair.
- _m_req0_a  in  WIDTH  requester 0 operand a.
- _m_req0_b  in  WIDTH  requester 0 operand b.
- _m_req1_valid  in  1  requester 1 has an operand pair.
- _m_req1_a  in  WIDTH  requester 1 operand a.
- _m_req1_b  in  WIDTH  requester 1 operand b.
- _m_max  in  WIDTH  shared saturation limit, sampled on the accepting edge.
- _m_out_ready  in  1  consumer accepts the output this cycle.
- __output  out  WIDTH+5  packed, MSB first:
  - req0_ready (bit WIDTH+4)
  - req1_ready (bit WIDTH+3)
  - out_valid (bit WIDTH+2)
  - out_id (bit WIDTH+1)
  - out_sat (bit WIDTH)
  - out_data (bits WIDTH-1:0)

## Operation
State: output register {out_valid, out_id, out_sat, out_data}, plus the last-served pointer `last` (1 bit).

- **Buffer free:** `free = !out_valid || _m_out_ready`.
- **Grant (combinational):**
  - Only reqi_valid is high: grant = i.
  - Both are high: grant = !last, i.e. the requester not served most recently.
  - Neither is high: no grant.
- **Ready:** reqi_ready = free && grant == i && reqi_valid. At most one ready is high per cycle. The ready outputs depend combinationally on both valid inputs and on _m_out_ready.
- **Accept:** happens in a cycle where reqi_valid && reqi_ready. On that edge:
  - sum = a + b, computed in WIDTH+1 bits with no wrap.
  - If sum > _m_max: out_data = _m_max, out_sat = 1.
  - Otherwise: out_data = sum[WIDTH-1:0], out_sat = 0.
  - out_id = i, out_valid = 1, last = i.
- **Drain:** if out_valid && _m_out_ready and no accept occurs, out_valid goes to 0 on the edge. out_id, out_sat and out_data hold their values.
- **Simultaneous drain and accept:** the new result replaces the old one and out_valid stays 1. This gives a throughput of one operation per cycle.
- **Stall:** if out_valid && !_m_out_ready, both readys are 0 and the output register holds. `last` does not change while stalled.
- **Requester rules:** requesters hold valid and operands stable until accepted. The block does not check this.
- **No-grant cycles:** `last` changes only on accept.

## Timing
- Reset values, applied asynchronously:
  - out_valid = 0, out_id = 0, out_sat = 0, out_data = 0.
  - last = 1, so requester 0 wins the first contested cycle.
  - req0_ready and req1_ready follow their combinational definitions. After reset, reqi_ready = reqi_valid && grant == i.
- Reset asserted mid-operation: a pending output is dropped, with no completion.
- Latency: a request accepted on edge N has its result visible on out_* after edge N, i.e. during cycle N+1.
- Fairness: under continuous contention, grants alternate 0,1,0,1… A requester waits at most one accepted transfer from the other requester.
- Boundaries:
  - a + b carrying out of WIDTH bits: saturates when _m_max ≤ 2^WIDTH−1. Example at WIDTH = 8: 255 + 1 → sum 256 > max.
  - sum == _m_max: not saturated, out_sat = 0.
  - _m_max = 0: every nonzero sum → 0 with out_sat = 1. 0 + 0 → 0 with out_sat = 0.

## Test plan
- **Reset values:** reset pulse, all inputs 0 → __output == 0. Then req0_valid = 1 → req0_ready = 1 in the same cycle.
- **Single requester, basic and saturated:**
  - req0 a = 1, b = 2, max = 5, out_ready = 1 → next cycle out_valid = 1, id = 0, data = 3, sat = 0.
  - Repeat with max = 2 → data = 2, sat = 1.
- **Carry-out saturation:** req1 a = 200, b = 100, max = 255 → data = 255, sat = 1, id = 1.
- **Contention:** both valid continuously for 4 cycles with out_ready = 1 → out_id sequence 0,1,0,1 on consecutive cycles, with out_valid high throughout.
- **Backpressure:**
  - Accept a request from req0, then hold out_ready = 0 for 3 cycles with both valid → both readys are 0 and out_data holds.
  - Then raise out_ready → req1 is accepted in that cycle and its result replaces the old one the next cycle.
- **Reset mid-operation:** out_valid = 1 and stalled; assert _m_rst asynchronously between edges → out_valid = 0 immediately. After release, the first contested grant goes to req0.
